// File: rtl/noc_flit_channel_arbiter_mux_if.sv
// Shared NoC configuration and the flit channel interface.
// A flit is {head, tail, data}: head in the MSB, tail just below it.
package noc_config_pkg;

    typedef struct packed {
        int unsigned data_w;
    } noc_config_t;

    localparam noc_config_t NOC_DEFAULT_CONFIG = '{data_w: 32'd32};

    // Total flit width: payload plus the head and tail flags.
    function automatic int flit_width(input noc_config_t cfg);
        return int'(cfg.data_w) + 2;
    endfunction

endpackage

// One valid/ready flit channel. The initiator drives valid and flit and
// the target returns ready.
interface noc_flit_channel_if #(
    parameter int FLIT_W = 34
) ();
    logic              valid;
    logic              ready;
    logic [FLIT_W-1:0] flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_flit_channel_arbiter_mux.sv
// Packet-atomic round-robin merge of several flit channels onto one, with an
// optional output FIFO that cuts the combinational arbitration path.

// Small synchronous FIFO carrying whole flits; o_ready is the not-full flag.
module noc_flit_channel_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_flit,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_flit
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_s, pop_s;

    // Pointer increment with explicit wrap, DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        if (p == AW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + {{(AW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign o_ready = (cnt_q != CW'(DEPTH));
    assign o_valid = (cnt_q != {CW{1'b0}});
    assign o_flit  = mem_q[rd_q];
    assign push_s  = i_valid & o_ready;
    assign pop_s   = o_valid & i_ready;

    // Next-state for read/write pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (i_clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_d  = ptr_inc(wr_q);
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
                2'b01: begin
                    rd_d  = ptr_inc(rd_q);
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
                2'b11: begin
                    wr_d = ptr_inc(wr_q);
                    rd_d = ptr_inc(rd_q);
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Pointer/occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s && !i_clear) begin
            mem_q[wr_q] <= i_flit;
        end
    end
endmodule

// Per-packet round-robin arbiter and mux.
module noc_flit_channel_arbiter_mux
    import noc_config_pkg::*;
#(
    parameter noc_config_t CONFIG     = NOC_DEFAULT_CONFIG,
    parameter int          CHANNELS   = 5,
    parameter int          FIFO_DEPTH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [CHANNELS-1:0]   o_grant,
    output logic                  o_locked,
    noc_flit_channel_if.target    flit_in_if [CHANNELS],
    noc_flit_channel_if.initiator flit_out_if
);
    localparam int FLIT_W   = flit_width(CONFIG);
    localparam int TAIL_BIT = FLIT_W - 2;
    localparam int IDX_W    = $clog2(CHANNELS);
    localparam logic [CHANNELS-1:0] GRANT_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;

    logic [CHANNELS-1:0] in_valid_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [FLIT_W-1:0]   in_flit_s [CHANNELS];

    logic [IDX_W-1:0]  idle_idx_s;
    logic              idle_hit_s;
    logic [IDX_W-1:0]  cand_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_any_s;
    logic              path_valid_s;
    logic              path_ready_s;
    logic [FLIT_W-1:0] path_flit_s;
    logic              xfer_s;
    logic              tail_s;

    // base + off modulo CHANNELS; both operands are below CHANNELS.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(CHANNELS)) begin
            sum = sum - 32'(CHANNELS);
        end
        return sum[IDX_W-1:0];
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign in_valid_s[i]       = flit_in_if[i].valid;
        assign in_flit_s[i]        = flit_in_if[i].flit;
        assign in_ready_s[i]       = rst_n & grant_any_s & path_ready_s &
                                     (grant_idx_s == IDX_W'(i));
        assign flit_in_if[i].ready = in_ready_s[i];
    end

    // Round-robin search for the first valid input starting at the pointer.
    always_comb begin
        idle_idx_s = '0;
        idle_hit_s = 1'b0;
        cand_s     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand_s = wrap_add(ptr_q, 32'(k));
            if (!idle_hit_s && in_valid_s[cand_s]) begin
                idle_hit_s = 1'b1;
                idle_idx_s = cand_s;
            end else begin
                idle_hit_s = idle_hit_s;
            end
        end
    end

    // Grant selection: held index while locked, otherwise the search result.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            grant_idx_s = lock_idx_q;
            grant_any_s = 1'b1;
        end else begin
            grant_idx_s = idle_idx_s;
            grant_any_s = idle_hit_s;
        end
    end

    // Granted input onto the arbitration path and status outputs.
    always_comb begin
        path_valid_s = rst_n & grant_any_s & in_valid_s[grant_idx_s];
        if (grant_any_s) begin
            path_flit_s = in_flit_s[grant_idx_s];
            o_grant     = GRANT_ONE << grant_idx_s;
        end else begin
            path_flit_s = '0;
            o_grant     = '0;
        end
        o_locked = (state_q == ST_LOCKED);
        xfer_s   = path_valid_s & path_ready_s;
        tail_s   = path_flit_s[TAIL_BIT];
    end

    // Packet lock FSM: lock on a non-tail transfer, release on tail.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (tail_s) begin
                        ptr_d = wrap_add(grant_idx_s, 32'd1);
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant_idx_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && tail_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = wrap_add(lock_idx_q, 32'd1);
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and lock registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    if (FIFO_DEPTH == 0) begin : g_direct
        assign path_ready_s      = flit_out_if.ready;
        assign flit_out_if.valid = path_valid_s;
        assign flit_out_if.flit  = path_flit_s;
    end else begin : g_fifo
        logic fifo_valid_s;

        noc_flit_channel_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (1'b0),
            .i_valid (path_valid_s),
            .o_ready (path_ready_s),
            .i_flit  (path_flit_s),
            .o_valid (fifo_valid_s),
            .i_ready (flit_out_if.ready),
            .o_flit  (flit_out_if.flit)
        );

        assign flit_out_if.valid = fifo_valid_s & rst_n;
    end
endmodule

// File: tb/tb_noc_flit_channel_arbiter_mux.sv
// Directed bench: a vector table drives the combinational instance, and a
// hand-written sequence exercises the FIFO_DEPTH=2 instance.
module tb_noc_flit_channel_arbiter_mux;
    import noc_config_pkg::*;

    localparam int CH = 5;
    localparam int FW = 34;

    typedef struct {
        logic          rst;
        logic [CH-1:0] vld;
        logic [CH-1:0] hd;
        logic [CH-1:0] tl;
        logic          ordy;
        logic [CH-1:0] exp_gnt;
        logic          exp_ov;
        logic [CH-1:0] exp_rdy;
        logic          exp_lock;
        logic [2:0]    exp_ptr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [CH-1:0] vld0, rdy0, gnt0;
    logic [FW-1:0] flit0 [CH];
    logic          ordy0, ov0, lock0;
    logic [FW-1:0] oflit0;

    logic [CH-1:0] vld2, rdy2, gnt2;
    logic [FW-1:0] flit2 [CH];
    logic          ordy2, ov2, lock2;
    logic [FW-1:0] oflit2;

    noc_flit_channel_if #(.FLIT_W(FW)) in0_if [CH] ();
    noc_flit_channel_if #(.FLIT_W(FW)) out0_if ();
    noc_flit_channel_if #(.FLIT_W(FW)) in2_if [CH] ();
    noc_flit_channel_if #(.FLIT_W(FW)) out2_if ();

    for (genvar i = 0; i < CH; i++) begin : g_conn
        assign in0_if[i].valid = vld0[i];
        assign in0_if[i].flit  = flit0[i];
        assign rdy0[i]         = in0_if[i].ready;
        assign in2_if[i].valid = vld2[i];
        assign in2_if[i].flit  = flit2[i];
        assign rdy2[i]         = in2_if[i].ready;
    end
    assign out0_if.ready = ordy0;
    assign ov0           = out0_if.valid;
    assign oflit0        = out0_if.flit;
    assign out2_if.ready = ordy2;
    assign ov2           = out2_if.valid;
    assign oflit2        = out2_if.flit;

    noc_flit_channel_arbiter_mux #(.CHANNELS(CH), .FIFO_DEPTH(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_grant     (gnt0),
        .o_locked    (lock0),
        .flit_in_if  (in0_if),
        .flit_out_if (out0_if)
    );

    noc_flit_channel_arbiter_mux #(.CHANNELS(CH), .FIFO_DEPTH(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_grant     (gnt2),
        .o_locked    (lock2),
        .flit_in_if  (in2_if),
        .flit_out_if (out2_if)
    );

    int checks = 0;
    int errors = 0;
    int cnt0 [CH];
    int acc0 [CH];
    vec_t tbl [$];
    int fair_start, fair_end;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [CH-1:0] vld,
                                input logic [CH-1:0] hd, input logic [CH-1:0] tl,
                                input logic ordy, input logic [CH-1:0] gnt,
                                input logic ov, input logic [CH-1:0] rdy,
                                input logic lock, input logic [2:0] ptr);
        vec_t v;
        v.rst = rst; v.vld = vld; v.hd = hd; v.tl = tl; v.ordy = ordy;
        v.exp_gnt = gnt; v.exp_ov = ov; v.exp_rdy = rdy;
        v.exp_lock = lock; v.exp_ptr = ptr;
        return v;
    endfunction

    // Flit of the single-input FIFO packet: 8 flits, head first, tail last.
    function automatic logic [FW-1:0] fflit(input int s);
        return {(s == 0), (s == 7), 16'd0, 16'(s)};
    endfunction

    // One table row: drive at negedge, check combinational outputs, clock,
    // check the pointer, then advance the per-input sequence numbers.
    task automatic apply(input vec_t v, input int n);
        int idx;
        logic [FW-1:0] ef;
        @(negedge clk);
        rst_n = ~v.rst;
        vld0  = v.vld;
        ordy0 = v.ordy;
        for (int i = 0; i < CH; i++) begin
            flit0[i] = {v.hd[i], v.tl[i], 16'(i), 16'(cnt0[i])};
        end
        #1;
        chk($sformatf("v%0d grant", n), 64'(gnt0), 64'(v.exp_gnt));
        chk($sformatf("v%0d out_valid", n), 64'(ov0), 64'(v.exp_ov));
        chk($sformatf("v%0d in_ready", n), 64'(rdy0), 64'(v.exp_rdy));
        chk($sformatf("v%0d locked", n), 64'(lock0), 64'(v.exp_lock));
        if (v.exp_ov) begin
            idx = 0;
            for (int i = 0; i < CH; i++) begin
                if (v.exp_gnt[i]) idx = i;
            end
            ef = {v.hd[idx], v.tl[idx], 16'(idx), 16'(cnt0[idx])};
            chk($sformatf("v%0d out_flit", n), 64'(oflit0), 64'(ef));
        end
        for (int i = 0; i < CH; i++) begin
            acc0[i] += int'(rdy0[i] & vld0[i]);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pointer", n), 64'(dut0.ptr_q), 64'(v.exp_ptr));
        for (int i = 0; i < CH; i++) begin
            if (v.exp_rdy[i] && v.vld[i]) cnt0[i]++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv, last_c;
        logic acc_in, acc_out;

        rst_n = 1'b0;
        vld0 = '0; ordy0 = 1'b0;
        vld2 = '0; ordy2 = 1'b0;
        for (int i = 0; i < CH; i++) begin
            flit0[i] = '0; flit2[i] = '0; cnt0[i] = 0; acc0[i] = 0;
        end
        repeat (2) @(posedge clk);

        // Reset gating, then reset state.
        tbl.push_back(mk(1, 5'b00100, 5'b00100, 5'b00100, 1, 5'b00100, 0, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 3'd0));
        // Contention: inputs 0 and 3, 3-flit packets, pointer 0.
        tbl.push_back(mk(0, 5'b01001, 5'b01001, 5'b00000, 1, 5'b00001, 1, 5'b00001, 0, 3'd0));
        tbl.push_back(mk(0, 5'b01001, 5'b01000, 5'b00000, 1, 5'b00001, 1, 5'b00001, 1, 3'd0));
        tbl.push_back(mk(0, 5'b01001, 5'b01000, 5'b00001, 1, 5'b00001, 1, 5'b00001, 1, 3'd1));
        tbl.push_back(mk(0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 1, 5'b01000, 0, 3'd1));
        tbl.push_back(mk(0, 5'b01000, 5'b00000, 5'b00000, 1, 5'b01000, 1, 5'b01000, 1, 3'd1));
        tbl.push_back(mk(0, 5'b01000, 5'b00000, 5'b01000, 1, 5'b01000, 1, 5'b01000, 1, 3'd4));
        // Single input 2, 4-flit packet.
        tbl.push_back(mk(0, 5'b00100, 5'b00100, 5'b00000, 1, 5'b00100, 1, 5'b00100, 0, 3'd4));
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 1, 5'b00100, 1, 3'd4));
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 1, 5'b00100, 1, 3'd4));
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 1, 5'b00100, 1, 5'b00100, 1, 3'd3));
        // Input 1 packet with a 2-cycle bubble and 3 cycles of backpressure;
        // input 4 holds a single-flit packet throughout.
        tbl.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 5'b00010, 0, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10000, 1, 5'b00010, 1, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, 1, 5'b00010, 0, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, 1, 5'b00010, 0, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10000, 0, 5'b00010, 1, 5'b00000, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10000, 0, 5'b00010, 1, 5'b00000, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10000, 0, 5'b00010, 1, 5'b00000, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10000, 1, 5'b00010, 1, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(0, 5'b10010, 5'b10000, 5'b10010, 1, 5'b00010, 1, 5'b00010, 1, 3'd2));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, 1, 5'b10000, 1, 5'b10000, 0, 3'd0));
        // Fairness: all inputs stream single-flit packets.
        fair_start = tbl.size();
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001 << (k % 5), 1,
                             5'b00001 << (k % 5), 0, 3'((k % 5 + 1) % 5)));
        end
        fair_end = tbl.size() - 1;
        // Reset in the middle of a 4-flit packet from input 1.
        tbl.push_back(mk(0, 5'b00100, 5'b00100, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 3'd3));
        tbl.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 5'b00010, 0, 3'd3));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 1, 5'b00010, 1, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(1, 5'b00010, 5'b00000, 5'b00000, 1, 5'b00010, 0, 5'b00000, 1, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 1, 5'b01000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b01000, 5'b00000, 5'b01000, 1, 5'b01000, 1, 5'b01000, 1, 3'd4));

        for (int n = 0; n < tbl.size(); n++) begin
            if (n == fair_start) begin
                for (int i = 0; i < CH; i++) acc0[i] = 0;
            end
            apply(tbl[n], n);
            if (n == fair_end) begin
                for (int i = 0; i < CH; i++) begin
                    chk($sformatf("fair flits input%0d", i), 64'(acc0[i]), 64'd2);
                end
            end
        end

        // FIFO_DEPTH=2: 8-flit packet from input 0, output stalled 4 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        vld0  = '0;
        sent = 0; recv = 0; last_c = -1;
        for (int c = 0; c < 30 && recv < 8; c++) begin
            @(negedge clk);
            vld2     = (sent < 8) ? 5'b00001 : 5'b00000;
            flit2[0] = fflit(sent);
            ordy2    = (c >= 4);
            #1;
            case (c)
                0: begin
                    chk("f0 grant", 64'(gnt2), 64'(5'b00001));
                    chk("f0 in_ready", 64'(rdy2[0]), 64'd1);
                    chk("f0 out_valid", 64'(ov2), 64'd0);
                end
                1: begin
                    chk("f1 in_ready", 64'(rdy2[0]), 64'd1);
                    chk("f1 out_valid", 64'(ov2), 64'd1);
                    chk("f1 out_flit", 64'(oflit2), 64'(fflit(0)));
                    chk("f1 locked", 64'(lock2), 64'd1);
                end
                2, 3: begin
                    chk($sformatf("f%0d in_ready full", c), 64'(rdy2[0]), 64'd0);
                    chk($sformatf("f%0d locked", c), 64'(lock2), 64'd1);
                end
                4: begin
                    chk("f4 in_ready", 64'(rdy2[0]), 64'd0);
                    chk("f4 out_valid", 64'(ov2), 64'd1);
                    chk("f4 out_flit", 64'(oflit2), 64'(fflit(0)));
                end
                default: begin
                    chk($sformatf("f%0d out_valid", c), 64'(ov2), 64'd1);
                    chk($sformatf("f%0d out_flit", c), 64'(oflit2), 64'(fflit(recv)));
                    if (sent >= 1 && sent < 8) begin
                        chk($sformatf("f%0d locked", c), 64'(lock2), 64'd1);
                    end
                end
            endcase
            acc_in  = vld2[0] & rdy2[0];
            acc_out = ov2 & ordy2;
            @(posedge clk);
            if (acc_in) sent++;
            if (acc_out) recv++;
            last_c = c;
        end
        chk("fifo flits sent", 64'(sent), 64'd8);
        chk("fifo flits received", 64'(recv), 64'd8);
        chk("fifo drain cycle", 64'(last_c), 64'd11);
        @(negedge clk);
        ordy2 = 1'b0;
        #1;
        chk("fifo end locked", 64'(lock2), 64'd0);
        chk("fifo end out_valid", 64'(ov2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
